// File: rtl/cba_seq_add_ctrl_pkg.sv
// cba_seq_add_ctrl_pkg: shared FSM state encoding and slice width for the sequential carry bypass adder
package cba_pkg;
  localparam int SLICE_W = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
endpackage

// File: rtl/cba_seq_add_ctrl_if.sv
// cba_seq_add_ctrl_if: operand/result handshake bundle; bypass_cnt exists only with CBA_SEQ_BYPASS_STAT_EN
interface cba_seq_add_ctrl_if #(parameter int WIDTH = 16);
    localparam int NIB = WIDTH / 4;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef CBA_SEQ_BYPASS_STAT_EN
    logic [$clog2(NIB+1)-1:0] bypass_cnt;
    modport master (output in_valid, a, b, cin, out_ready,
                    input in_ready, out_valid, sum, cout, busy, bypass_cnt);
    modport slave (input in_valid, a, b, cin, out_ready,
                   output in_ready, out_valid, sum, cout, busy, bypass_cnt);
`else
    modport master (output in_valid, a, b, cin, out_ready,
                    input in_ready, out_valid, sum, cout, busy);
    modport slave (input in_valid, a, b, cin, out_ready,
                   output in_ready, out_valid, sum, cout, busy);
`endif
endinterface

// File: rtl/cba_seq_add_ctrl_slice.sv
// cba4_slice: combinational 4-bit carry bypass adder; cout skips the ripple chain when all propagates are set
module cba4_slice
    import cba_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic               cout,
    output logic               p_all
);
    logic [SLICE_W-1:0] p;
    logic [SLICE_W-1:0] g;
    logic               cr;
    assign p = a ^ b;
    assign g = a & b;
    assign p_all = &p;
    always_comb begin
        cr = cin;
        s = '0;
        for (int i = 0; i < SLICE_W; i++) begin
            s[i] = p[i] ^ cr;
            cr = g[i] | (p[i] & cr);
        end
        cout = p_all ? cin : cr;
    end
endmodule

// File: rtl/cba_seq_add_ctrl.sv
// cba_seq_add_ctrl: WIDTH-bit adder built by time-multiplexing one 4-bit carry bypass slice, LSB nibble first.
// Optional bypass statistics counter enabled by defining CBA_SEQ_BYPASS_STAT_EN.
module cba_seq_add_ctrl
    import cba_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input logic              clk,
    input logic              rst,
    cba_seq_add_ctrl_if.slave bus
);
    localparam int NIB = WIDTH / SLICE_W;
    localparam int IW = NIB > 1 ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIB - 1);
    localparam logic [1:0] S_IDLE = 2'(IDLE);
    localparam logic [1:0] S_RUN = 2'(RUN);
    localparam logic [1:0] S_DONE = 2'(DONE);

    logic [1:0]         st;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   sum_r;
    logic               carry;
    logic               cout_r;
    logic [IW-1:0]      idx;
    logic [SLICE_W-1:0] s_s;
    logic               s_co;
    logic               s_pall;
    logic               accept;

    assign accept = st == S_IDLE && bus.in_valid;

    cba4_slice u_slice (
        .a    (a_r[idx*SLICE_W +: SLICE_W]),
        .b    (b_r[idx*SLICE_W +: SLICE_W]),
        .cin  (carry),
        .s    (s_s),
        .cout (s_co),
        .p_all(s_pall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= S_IDLE;
            a_r <= '0;
            b_r <= '0;
            sum_r <= '0;
            carry <= 1'b0;
            cout_r <= 1'b0;
            idx <= '0;
        end else if (st == S_IDLE) begin
            if (accept) begin
                st <= S_RUN;
                a_r <= bus.a;
                b_r <= bus.b;
                carry <= bus.cin;
                idx <= '0;
            end
        end else if (st == S_RUN) begin
            sum_r[idx*SLICE_W +: SLICE_W] <= s_s;
            carry <= s_co;
            // idx saturates at the last nibble; only a new accept rewinds it
            if (idx == LAST) begin
                st <= S_DONE;
                cout_r <= s_co;
            end else begin
                idx <= idx + 1'b1;
            end
        end else if (bus.out_ready) begin
            st <= S_IDLE;
        end
    end

    assign bus.in_ready = st == S_IDLE;
    assign bus.out_valid = st == S_DONE;
    assign bus.busy = st == S_RUN || st == S_DONE;
    assign bus.sum = sum_r;
    assign bus.cout = cout_r;

`ifdef CBA_SEQ_BYPASS_STAT_EN
    logic [$clog2(NIB+1)-1:0] byp;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) byp <= '0;
        else if (accept) byp <= '0;
        else if (st == S_RUN && s_pall) byp <= byp + 1'b1;
    end
    assign bus.bypass_cnt = byp;
`endif
endmodule

// File: tb/tb_cba_seq_add_ctrl.sv
// tb_cba_seq_add_ctrl: directed and random scoreboard checks of the sequential carry bypass adder
module tb_cba_seq_add_ctrl;
    localparam int W = 16;
    localparam int NIB = W / 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    logic [W:0] exp_q[$];
    int   byp_q[$];

    always #5 clk = ~clk;

    cba_seq_add_ctrl_if #(.WIDTH(W)) bus ();
    cba_seq_add_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int nib_bypass(input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        logic [W-1:0] x = a ^ b;
        for (int i = 0; i < NIB; i++) if (x[i*4 +: 4] == 4'hF) n++;
        return n;
    endfunction

    // accept one operand pair and push its reference result
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int n = 0;
        while (!bus.in_ready && n < 20) begin tick(); n++; end
        if (!bus.in_ready) chk("in_ready_timeout", 0, 1);
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.cin = c;
        exp_q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, c});
        byp_q.push_back(nib_bypass(a, b));
        tick();
        bus.in_valid = 1'b0;
        bus.a = W'($urandom);
        bus.b = W'($urandom);
        bus.cin = 1'(($urandom));
    endtask

    // wait for result, optionally check latency, hold for stall cycles, then handshake and compare
    task automatic recv(input int stall, input bit chk_lat, input bit chk_hold);
        int n = 0;
        logic [W:0] e;
        logic [W-1:0] s0;
        logic c0;
        int eb;
        while (!bus.out_valid && n < 20) begin tick(); n++; end
        if (!bus.out_valid) begin
            chk("out_valid_timeout", 0, 1);
            return;
        end
        if (chk_lat) chk("latency", n, NIB);
        s0 = bus.sum;
        c0 = bus.cout;
        for (int i = 0; i < stall; i++) begin
            if (chk_hold) begin
                bus.in_valid = 1'b1;
                bus.a = 16'hAAAA;
                bus.b = 16'h5555;
                chk("hold_in_ready", bus.in_ready, 0);
            end
            tick();
            if (chk_hold) begin
                chk("hold_sum", bus.sum, s0);
                chk("hold_valid", bus.out_valid, 1);
            end else if (bus.sum !== s0 || bus.cout !== c0) chk("stall_stable", {bus.cout, bus.sum}, {c0, s0});
        end
        bus.in_valid = 1'b0;
        e = exp_q.pop_front();
        eb = byp_q.pop_front();
        chk("result", {bus.cout, bus.sum}, e);
`ifdef CBA_SEQ_BYPASS_STAT_EN
        chk("bypass_cnt", bus.bypass_cnt, eb);
`else
        if (eb < 0) chk("bypass_model", eb, 0);
`endif
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        if (chk_hold) begin
            chk("idle_in_ready", bus.in_ready, 1);
            chk("idle_out_valid", bus.out_valid, 0);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_sum", bus.sum, 0);
        rst = 1'b0;
        tick();

        send(16'h1234, 16'h4321, 1'b0);
        chk("run_busy", bus.busy, 1);
        chk("run_in_ready", bus.in_ready, 0);
        recv(0, 1'b1, 1'b0);
        chk("sum_1234", {bus.cout, bus.sum}, 17'h05555);

        send(16'hFFFF, 16'h0001, 1'b0);
        recv(0, 1'b1, 1'b0);
        chk("ripple", {bus.cout, bus.sum}, 17'h10000);

        send(16'hFFFF, 16'h0000, 1'b1);
        recv(0, 1'b1, 1'b0);
        chk("bypass_all", {bus.cout, bus.sum}, 17'h10000);

        send(16'h1234, 16'h4321, 1'b1);
        recv(10, 1'b1, 1'b1);

        send(16'hDEAD, 16'hBEEF, 1'b1);
        tick();
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_sum", bus.sum, 0);
        chk("mid_rst_in_ready", bus.in_ready, 1);
        exp_q.delete();
        byp_q.delete();
        tick();
        rst = 1'b0;
        tick();
        send(16'h0F0F, 16'h00F1, 1'b0);
        recv(0, 1'b1, 1'b0);
        chk("after_rst", {bus.cout, bus.sum}, 17'h01000);

        for (int k = 0; k < 1000; k++) begin
            send(W'($urandom), W'($urandom), 1'(($urandom)));
            recv(int'($urandom_range(0, 3)), 1'b0, 1'b0);
        end
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
